preg_bank: RTL and testbench
============================

// Module: preg_bank
// PURPOSE
//  Peripheral register bank on the p-bus (paddr/pwdata/pwrite/pstrb/pread -> prdata/pready).
//  Sits directly downstream of the AHB-lite slave front end and is its pready/prdata target.
//  Provides NREGS byte-writable 32-bit registers, exported as a flat vector.
//  Inserts a programmable number of wait states per access.
// PARAMETERS
//  NREGS        8   number of general RW registers, 1..64; word-indexed by paddr[7:2]
//  WAIT_CYCLES  1   wait states before pready, 0..15
//  RST_VAL      0   32-bit reset value of every general register
// PORTS
//  hclk      in   1         clock, all logic on posedge
//  hresetn   in   1         asynchronous active-low reset
//  paddr     in   32        byte address, held stable until pready
//  pwdata    in   32        write data, valid with pwrite
//  pwrite    in   1         write request, held until pready
//  pstrb     in   4         byte enables for the write
//  pread     in   1         read request, held until pready
//  prdata    out  32        read data, valid when pread && pready
//  pready    out  1         transfer complete in this cycle
//  regs_out  out  32*NREGS  flat register contents; reg i = regs_out[32*i+:32]
//  irq_src   in   8         interrupt sources, PREG_BANK_IRQ_EN builds only
//  irq       out  1         interrupt, PREG_BANK_IRQ_EN builds only
// BEHAVIOUR
//  Reset values: regs = RST_VAL, state = IDLE, cnt = 0, prdata = 0, pready = (WAIT_CYCLES==0).
//  req = pwrite | pread. When both are high, the write wins; no read data is returned.
//  FSM IDLE/WAIT with a 4-bit down counter cnt:
//   IDLE, req, WAIT_CYCLES==0 : pready=1 combinationally; transfer completes this cycle.
//   IDLE, req, WAIT_CYCLES>0  : pready=0; go to WAIT, cnt <= WAIT_CYCLES-1.
//   WAIT                      : pready = (cnt==0); cnt decrements while >0; cnt==0 -> IDLE.
//   WAIT, req dropped         : abort; return to IDLE, no write, pready=0.
//  Latency: pready on the (WAIT_CYCLES+1)-th cycle of the request.
//  Back-to-back requests: after completion the FSM is IDLE; a still-high req starts a new access.
//  Write commits at the clock edge where pwrite && pready.
//   Byte k is written iff pstrb[k]; pstrb==0 writes nothing.
//  prdata = selected register when pread && pready && !pwrite, else 0. Combinational mux.
//  Address decode: idx = paddr[7:2]; paddr[1:0] and paddr[31:8] are ignored.
//  idx >= NREGS (and not a macro register): write dropped, read returns 0, pready timing unchanged.
//  Reset mid-access: FSM to IDLE; no partial write; registers return to RST_VAL.
// CONFIGURATION
//  PREG_BANK_IRQ_EN defined:
//   IRQ_PEND at idx NREGS: bit i sets on the rising edge of irq_src[i]; write-1-to-clear.
//   Same-cycle set and clear: set wins.
//   IRQ_MASK at idx NREGS+1: RW, reset 0.
//   irq = |(IRQ_PEND & IRQ_MASK), registered, reset 0.
//  PREG_BANK_IRQ_EN undefined: irq_src/irq ports absent; idx NREGS and NREGS+1 decode as out-of-range.
// STRUCTURE
//  preg_bank_pkg: FSM state enum {IDLE,WAIT}, IDX_IRQ_PEND/IDX_IRQ_MASK offsets, byte-merge function.
//  Sub-module preg_wait_ctr: FSM plus counter; inputs req, outputs pready.
//  Register array, decode and read mux stay in preg_bank.
// TESTING
//  WAIT_CYCLES=1; write 0x1122_3344 to 0x04 with pstrb=F
//   -> pready in cycle 2; regs_out[63:32]=0x11223344.
//  pstrb=4'b0010, pwdata=0xAABBCCDD to 0x04
//   -> reg1 = 0x1122_CC44; a read of 0x04 returns 0x1122CC44 with pready in cycle 2.
//  WAIT_CYCLES=3; drop pwrite in the 2nd cycle
//   -> pready never seen, reg unchanged; the next request takes a full 4 cycles.
//  Read 0x40 with NREGS=8 -> prdata=0, pready in normal cycle; a write there changes no regs_out bit.
//  Assert hresetn low during WAIT -> pready=(WAIT_CYCLES==0), prdata=0, all regs=RST_VAL.
//  PREG_BANK_IRQ_EN: pulse irq_src[2], IRQ_MASK=4 -> irq=1; write 4 to IRQ_PEND -> irq=0 next cycle.

Source files
------------

// File: rtl/preg_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : preg_bank_pkg
//  Purpose  : Shared types and helpers for the p-bus register bank.
//             - wait_state_e : wait-state FSM encoding (IDLE / WAIT)
//             - IDX_IRQ_*    : word offsets of the interrupt registers, relative
//                              to NREGS (used when PREG_BANK_IRQ_EN is defined)
//             - byte_merge   : applies a 4-bit byte-enable write to a word
//  Revision : 1.0  initial release
// ============================================================================
package preg_bank_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wait_state_e;

  // Interrupt registers sit directly above the general registers.
  localparam int IDX_IRQ_PEND_OFS = 0;
  localparam int IDX_IRQ_MASK_OFS = 1;

  // Byte k of the result comes from wdata when strb[k] is set, else from old.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) res[8*k +: 8] = wdata[8*k +: 8];
    end
    return res;
  endfunction

endpackage : preg_bank_pkg
`default_nettype wire

// File: rtl/preg_bank_if.sv
`default_nettype none
// ============================================================================
//  Interface : preg_bank_if
//  Purpose   : p-bus between the AHB-lite slave front end (master) and the
//              register bank (slave).
//  Signals   : paddr  [31:0] byte address, stable until pready
//              pwdata [31:0] write data
//              pwrite        write request, held until pready
//              pstrb  [3:0]  write byte enables
//              pread         read request, held until pready
//              prdata [31:0] read data (slave -> master)
//              pready        transfer completes this cycle (slave -> master)
//  Revision  : 1.0  initial release
// ============================================================================
interface preg_bank_if;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic [3:0]  pstrb;
  logic        pread;
  logic [31:0] prdata;
  logic        pready;

  modport master (
    output paddr, pwdata, pwrite, pstrb, pread,
    input  prdata, pready
  );

  modport slave (
    input  paddr, pwdata, pwrite, pstrb, pread,
    output prdata, pready
  );
endinterface : preg_bank_if
`default_nettype wire

// File: rtl/preg_wait_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : preg_wait_ctr
//  Purpose  : Wait-state generator for the p-bus. Asserts pready on the
//             (WAIT_CYCLES+1)-th cycle of a request; dropping req while
//             waiting aborts the access.
//  Ports    : clk     in   clock, posedge
//             rst_n   in   asynchronous active-low reset
//             req     in   pwrite | pread
//             pready  out  transfer completes this cycle (combinational)
//  Params   : WAIT_CYCLES  0..15 wait states
//  Revision : 1.0  initial release
// ============================================================================
module preg_wait_ctr
  import preg_bank_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic pready
);

  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  wait_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Zero-wait builds complete in the request cycle; pready is held
        // high in IDLE so reset and idle both present it.
        pready = (WAIT_CYCLES == 0);
        if (req && (WAIT_CYCLES != 0)) begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (!req) begin
          // Master abandoned the access: no completion, no write.
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          pready  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

endmodule : preg_wait_ctr
`default_nettype wire

// File: rtl/preg_bank.sv
`default_nettype none
// ============================================================================
//  Module   : preg_bank
//  Purpose  : Peripheral register bank on the p-bus. NREGS byte-writable
//             32-bit registers, word-indexed by paddr[7:2], exported flat,
//             with WAIT_CYCLES wait states per access.
//  Ports    : hclk      in   clock, posedge
//             hresetn   in   asynchronous active-low reset
//             bus       slave modport of preg_bank_if (p-bus)
//             regs_out  out  reg i = regs_out[32*i +: 32]
//             irq_src   in   [7:0] interrupt sources (PREG_BANK_IRQ_EN only)
//             irq       out  registered interrupt     (PREG_BANK_IRQ_EN only)
//  Params   : NREGS 1..64, WAIT_CYCLES 0..15, RST_VAL reset value of regs
//  Build    : define PREG_BANK_IRQ_EN to add IRQ_PEND (idx NREGS, W1C) and
//             IRQ_MASK (idx NREGS+1, RW); otherwise those indices are
//             out of range.
//  Revision : 1.0  initial release
// ============================================================================
module preg_bank
  import preg_bank_pkg::*;
#(
  parameter int          NREGS       = 8,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] RST_VAL     = 32'h0
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  preg_bank_if.slave           bus,
  output logic [32*NREGS-1:0]  regs_out
`ifdef PREG_BANK_IRQ_EN
  ,
  input  logic [7:0]           irq_src,
  output logic                 irq
`endif
);

  logic        req;
  logic        pready;
  logic [5:0]  idx;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] rdata_sel;
  logic        unused_addr_bits;

  assign req   = bus.pwrite | bus.pread;
  assign idx   = bus.paddr[7:2];
  // Write wins when both requests are high.
  assign wr_en = bus.pwrite && pready;
  assign rd_en = bus.pread && pready && !bus.pwrite;

  assign unused_addr_bits = ^{bus.paddr[31:8], bus.paddr[1:0]};

  preg_wait_ctr #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_ctr (
    .clk    (hclk),
    .rst_n  (hresetn),
    .req    (req),
    .pready (pready)
  );

  assign bus.pready = pready;

  // --------------------------------------------------------------------------
  // General registers
  // --------------------------------------------------------------------------
  logic [31:0] regs_q [NREGS];
  logic [31:0] regs_d [NREGS];

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    always_comb begin
      regs_d[i] = regs_q[i];
      if (wr_en && (idx == 6'(i))) begin
        regs_d[i] = byte_merge(regs_q[i], bus.pwdata, bus.pstrb);
      end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) regs_q[i] <= RST_VAL;
      else          regs_q[i] <= regs_d[i];
    end

    assign regs_out[32*i +: 32] = regs_q[i];
  end

`ifdef PREG_BANK_IRQ_EN
  // --------------------------------------------------------------------------
  // Interrupt registers
  // --------------------------------------------------------------------------
  logic [6:0] idx_ext;
  logic       sel_pend;
  logic       sel_mask;
  logic [7:0] irq_src_q, irq_src_d;
  logic [7:0] irq_pend_q, irq_pend_d;
  logic [7:0] irq_mask_q, irq_mask_d;
  logic       irq_q, irq_d;
  logic [7:0] rise;
  logic [7:0] clr;

  // 7-bit compare so NREGS=64 does not alias the interrupt registers onto idx 0.
  assign idx_ext  = {1'b0, idx};
  assign sel_pend = (idx_ext == 7'(NREGS + IDX_IRQ_PEND_OFS));
  assign sel_mask = (idx_ext == 7'(NREGS + IDX_IRQ_MASK_OFS));

  always_comb begin
    irq_src_d  = irq_src;
    rise       = irq_src & ~irq_src_q;
    clr        = (wr_en && sel_pend && bus.pstrb[0]) ? bus.pwdata[7:0] : 8'h00;
    // A new edge in the same cycle as its clear keeps the bit set.
    irq_pend_d = (irq_pend_q & ~clr) | rise;
    irq_mask_d = irq_mask_q;
    if (wr_en && sel_mask && bus.pstrb[0]) irq_mask_d = bus.pwdata[7:0];
    // Built from next-state so a clear is visible on irq the cycle after commit.
    irq_d      = |(irq_pend_d & irq_mask_d);
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      irq_src_q  <= 8'h00;
      irq_pend_q <= 8'h00;
      irq_mask_q <= 8'h00;
      irq_q      <= 1'b0;
    end else begin
      irq_src_q  <= irq_src_d;
      irq_pend_q <= irq_pend_d;
      irq_mask_q <= irq_mask_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

  // --------------------------------------------------------------------------
  // Read mux: unmapped indices read as zero
  // --------------------------------------------------------------------------
  always_comb begin
    rdata_sel = 32'h0;
    for (int i = 0; i < NREGS; i++) begin
      if (idx == 6'(i)) rdata_sel = regs_q[i];
    end
`ifdef PREG_BANK_IRQ_EN
    if (sel_pend) rdata_sel = {24'h0, irq_pend_q};
    if (sel_mask) rdata_sel = {24'h0, irq_mask_q};
`endif
  end

  assign bus.prdata = rd_en ? rdata_sel : 32'h0;

endmodule : preg_bank
`default_nettype wire

// File: tb/tb_preg_bank.sv
`timescale 1ns/1ps
module tb_preg_bank;

  localparam int          NREGS = 8;
  localparam logic [31:0] RST_B = 32'hDEAD_BEEF;

  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  always #5 hclk = ~hclk;

  preg_bank_if bus_a ();
  preg_bank_if bus_b ();
  logic [32*NREGS-1:0] regs_a, regs_b;
`ifdef PREG_BANK_IRQ_EN
  logic [7:0] irq_src_a;
  logic       irq_a, irq_b;
`endif

  // A: one wait state, reset 0.  B: three wait states, non-zero reset value.
  preg_bank #(.NREGS(NREGS), .WAIT_CYCLES(1), .RST_VAL(32'h0)) dut_a (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .bus      (bus_a),
    .regs_out (regs_a)
`ifdef PREG_BANK_IRQ_EN
    ,
    .irq_src  (irq_src_a),
    .irq      (irq_a)
`endif
  );

  preg_bank #(.NREGS(NREGS), .WAIT_CYCLES(3), .RST_VAL(RST_B)) dut_b (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .bus      (bus_b),
    .regs_out (regs_b)
`ifdef PREG_BANK_IRQ_EN
    ,
    .irq_src  (8'h00),
    .irq      (irq_b)
`endif
  );

  typedef struct {
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_a [NREGS];
  logic [31:0] model_b [NREGS];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [32*NREGS-1:0] flat(input bit b);
    logic [32*NREGS-1:0] v;
    for (int i = 0; i < NREGS; i++) v[32*i +: 32] = b ? model_b[i] : model_a[i];
    return v;
  endfunction

  // ---------------------------------------------------------------- monitors
  int   cyc_a = 0, cyc_b = 0;
  exp_t ea, eb;

  always @(negedge hclk) begin
    if (!hresetn || !(bus_a.pwrite | bus_a.pread)) cyc_a = 0;
    else begin
      cyc_a++;
      if (bus_a.pready) begin
        if (q_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_pready: got pready=1 expected no transfer");
        end else begin
          ea = q_a.pop_front();
          check("a_prdata", bus_a.prdata, ea.rdata);
          check("a_latency", cyc_a, ea.lat);
        end
        cyc_a = 0;
      end
    end
  end

  always @(negedge hclk) begin
    if (!hresetn || !(bus_b.pwrite | bus_b.pread)) cyc_b = 0;
    else begin
      cyc_b++;
      if (bus_b.pready) begin
        if (q_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_pready: got pready=1 expected no transfer");
        end else begin
          eb = q_b.pop_front();
          check("b_prdata", bus_b.prdata, eb.rdata);
          check("b_latency", cyc_b, eb.lat);
        end
        cyc_b = 0;
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic drive(input bit b, input bit wr, input bit rd, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb);
    if (!b) begin
      bus_a.pwrite = wr; bus_a.pread = rd; bus_a.paddr = addr;
      bus_a.pwdata = data; bus_a.pstrb = strb;
    end else begin
      bus_b.pwrite = wr; bus_b.pread = rd; bus_b.paddr = addr;
      bus_b.pwdata = data; bus_b.pstrb = strb;
    end
  endtask

  task automatic access(input bit b, input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        input logic [31:0] exp_rd);
    exp_t        e;
    bit          done;
    int          idx;
    logic [31:0] cur;
    e.rdata = exp_rd;
    e.lat   = b ? 4 : 2;
    if (b) q_b.push_back(e); else q_a.push_back(e);
    @(posedge hclk); #1;
    drive(b, wr, rd, addr, data, strb);
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge hclk);
      done = b ? bus_b.pready : bus_a.pready;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no pready expected pready", b ? "b" : "a");
    end
    @(posedge hclk);
    if (wr) begin
      idx = int'(addr[7:2]);
      if (idx < NREGS) begin
        cur = b ? model_b[idx] : model_a[idx];
        for (int k = 0; k < 4; k++) if (strb[k]) cur[8*k +: 8] = data[8*k +: 8];
        if (b) model_b[idx] = cur; else model_a[idx] = cur;
      end
    end
    #1;
    drive(b, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected $finish");
    $fatal(1);
  end

  initial begin
    int seen;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
`ifdef PREG_BANK_IRQ_EN
    irq_src_a = 8'h00;
`endif
    for (int i = 0; i < NREGS; i++) begin model_a[i] = 32'h0; model_b[i] = RST_B; end

    // Reset state
    repeat (2) @(posedge hclk);
    #1;
    check("a_rst_regs", regs_a, '0);
    check("b_rst_regs", regs_b, {NREGS{RST_B}});
    check("a_rst_pready", bus_a.pready, 0);
    check("b_rst_pready", bus_b.pready, 0);
    check("a_rst_prdata", bus_a.prdata, 0);
`ifdef PREG_BANK_IRQ_EN
    check("a_rst_irq", irq_a, 0);
`endif
    @(posedge hclk); #1 hresetn = 1'b1;

    // Full-word write, then partial byte write, then readback
    access(1'b0, 1'b1, 1'b0, 32'h04, 32'h1122_3344, 4'hF, 32'h0);
    check("a_reg1_full", regs_a[63:32], 32'h1122_3344);
    access(1'b0, 1'b1, 1'b0, 32'h04, 32'hAABB_CCDD, 4'b0010, 32'h0);
    check("a_reg1_strb", regs_a[63:32], 32'h1122_CC44);
    access(1'b0, 1'b0, 1'b1, 32'h04, 32'h0, 4'h0, 32'h1122_CC44);
    // Low and high address bits are ignored
    access(1'b0, 1'b0, 1'b1, 32'h07, 32'h0, 4'h0, 32'h1122_CC44);
    access(1'b0, 1'b0, 1'b1, 32'h104, 32'h0, 4'h0, 32'h1122_CC44);
    // pstrb==0 writes nothing
    access(1'b0, 1'b1, 1'b0, 32'h08, 32'hFFFF_FFFF, 4'h0, 32'h0);
    check("a_reg2_nostrb", regs_a[95:64], 32'h0);
    // Write and read together: write wins, prdata stays 0
    access(1'b0, 1'b1, 1'b1, 32'h0C, 32'h0000_0055, 4'hF, 32'h0);
    check("a_reg3_wr_wins", regs_a[127:96], 32'h0000_0055);
    // Out-of-range indices
    access(1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 4'h0, 32'h0);
    access(1'b0, 1'b1, 1'b0, 32'h40, 32'hFFFF_FFFF, 4'hF, 32'h0);
    access(1'b0, 1'b1, 1'b0, 32'hFC, 32'hFFFF_FFFF, 4'hF, 32'h0);
`ifndef PREG_BANK_IRQ_EN
    access(1'b0, 1'b1, 1'b0, 32'h20, 32'hFFFF_FFFF, 4'hF, 32'h0);
    access(1'b0, 1'b1, 1'b0, 32'h24, 32'hFFFF_FFFF, 4'hF, 32'h0);
    access(1'b0, 1'b0, 1'b1, 32'h24, 32'h0, 4'h0, 32'h0);
`endif
    check("a_regs_oor", regs_a, flat(1'b0));

    // Back-to-back: read held high across two completions
    q_a.push_back('{rdata: 32'h1122_CC44, lat: 2});
    q_a.push_back('{rdata: 32'h1122_CC44, lat: 2});
    @(posedge hclk); #1;
    drive(1'b0, 1'b0, 1'b1, 32'h04, 32'h0, 4'h0);
    seen = 0;
    for (int k = 0; k < 40 && seen < 2; k++) begin
      @(negedge hclk);
      if (bus_a.pready) seen++;
    end
    check("a_b2b_count", seen, 2);
    @(posedge hclk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // B: abort by dropping pwrite in the second cycle
    @(posedge hclk); #1;
    drive(1'b1, 1'b1, 1'b0, 32'h10, 32'hCAFE_F00D, 4'hF);
    @(posedge hclk); #1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge hclk);
      check("b_abort_pready", bus_b.pready, 0);
    end
    check("b_abort_reg4", regs_b[159:128], RST_B);
    access(1'b1, 1'b1, 1'b0, 32'h10, 32'h1234_5678, 4'hF, 32'h0);
    check("b_reg4_write", regs_b[159:128], 32'h1234_5678);
    access(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0, 32'h1234_5678);
    check("b_regs", regs_b, flat(1'b1));

    // Reset in the middle of a B wait
    @(posedge hclk); #1;
    drive(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
    repeat (2) @(posedge hclk);
    #3 hresetn = 1'b0;
    #1;
    check("b_midrst_pready", bus_b.pready, 0);
    check("b_midrst_prdata", bus_b.prdata, 0);
    check("b_midrst_regs", regs_b, {NREGS{RST_B}});
    check("a_midrst_regs", regs_a, '0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < NREGS; i++) begin model_a[i] = 32'h0; model_b[i] = RST_B; end
    @(posedge hclk); #1 hresetn = 1'b1;
    access(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0, RST_B);

`ifdef PREG_BANK_IRQ_EN
    // Interrupt: mask bit 2, pulse source 2, then clear pending
    access(1'b0, 1'b1, 1'b0, 32'h24, 32'h0000_0004, 4'hF, 32'h0);
    check("a_irq_idle", irq_a, 0);
    @(posedge hclk); #1 irq_src_a = 8'h04;
    @(posedge hclk); #1 irq_src_a = 8'h00;
    check("a_irq_set", irq_a, 1);
    access(1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 4'h0, 32'h0000_0004);
    access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0000_0004, 4'hF, 32'h0);
    check("a_irq_clr", irq_a, 0);
`endif

    repeat (3) @(posedge hclk);
    check("a_queue_empty", q_a.size(), 0);
    check("b_queue_empty", q_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
